// File: rtl/traffic_measure_ctrl.sv
// Measurement sequencer plus N-way round-robin merge of logger timestamp streams.
// Latency: control outputs registered (1 cycle after cause); merged beat valid 1 cycle after acceptance.
// Backpressure: output register holds while !ts_out_TREADY; input ready is granted only when the register can load.
module traffic_measure_ctrl #(
    parameter int N_LOGGERS    = 4,
    parameter int WINDOW_WIDTH = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WINDOW_WIDTH-1:0]   window_len,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               session_id,
    output logic [63:0]               current_time,
    output logic                      measure,
    input  logic [64*N_LOGGERS-1:0]   ts_in_TDATA,
    input  logic [N_LOGGERS-1:0]      ts_in_TVALID,
    output logic [N_LOGGERS-1:0]      ts_in_TREADY,
    output logic [63:0]               ts_out_TDATA,
    output logic [7:0]                ts_out_TKEEP,
    output logic [15:0]               ts_out_TDEST,
    output logic [15:0]               ts_out_TID,
    output logic                      ts_out_TLAST,
    output logic                      ts_out_TVALID,
    input  logic                      ts_out_TREADY
);

    localparam int IW = $clog2(N_LOGGERS);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [WINDOW_WIDTH-1:0] WIN_ONE = WINDOW_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [WINDOW_WIDTH-1:0] rem_q, rem_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [15:0]             session_q, session_d;
    logic [63:0]             time_q, time_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    measure_q, measure_d;

    logic [IW-1:0]           ptr_q, ptr_d;
    logic                    out_vld_q, out_vld_d;
    logic [63:0]             out_dat_q, out_dat_d;
    logic [IW-1:0]           out_dest_q, out_dest_d;
    logic [15:0]             out_tid_q, out_tid_d;

    logic                    can_load;
    logic                    grant_vld;
    logic [IW-1:0]           grant_idx;
    logic [IW:0]             cand;

    // Session FSM; the window counter is loaded on start and counts down while measuring.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        session_d = session_q;
        time_d    = time_q + 64'd1;
        case (state_q)
            IDLE: begin
                if (start && (window_len != '0)) begin
                    rem_d     = window_len;
                    session_d = session_q + 16'd1;
                    state_d   = ARM;
                end
            end
            ARM: state_d = MEASURE;
            MEASURE: begin
                rem_d = rem_q - WIN_ONE;
                // abort and final count collapse into the same single transition
                if (abort || (rem_q == WIN_ONE)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                // minimum dwell first, then wait for every stream to be empty
                if (drain_q == DRAIN_LAST) begin
                    if ((ts_in_TVALID == '0) && !out_vld_q) begin
                        state_d = DONE;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        measure_d = (state_d == MEASURE);
    end

    // Round-robin search upward from the pointer; a grant needs room in the output register.
    always_comb begin
        can_load  = !out_vld_q || ts_out_TREADY;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N_LOGGERS; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_LOGGERS)) begin
                cand = cand - (IW+1)'(N_LOGGERS);
            end
            if (!grant_vld && ts_in_TVALID[cand[IW-1:0]]) begin
                grant_vld = can_load;
                grant_idx = cand[IW-1:0];
            end
        end
        ts_in_TREADY = '0;
        if (grant_vld) begin
            ts_in_TREADY[grant_idx] = 1'b1;
        end
    end

    // Output register and pointer update: load on grant, empty on handshake, otherwise hold.
    always_comb begin
        ptr_d      = ptr_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_dest_d = out_dest_q;
        out_tid_d  = out_tid_q;
        if (grant_vld) begin
            out_vld_d  = 1'b1;
            out_dat_d  = ts_in_TDATA[{grant_idx, 6'b0} +: 64];
            out_dest_d = grant_idx;
            out_tid_d  = session_q;
            ptr_d      = (grant_idx == IW'(N_LOGGERS - 1)) ? '0 : grant_idx + IW'(1);
        end else if (out_vld_q && ts_out_TREADY) begin
            out_vld_d = 1'b0;
        end
    end

    // All state registers; reset clears everything including the time base and session count.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            drain_q    <= '0;
            session_q  <= '0;
            time_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            measure_q  <= 1'b0;
            ptr_q      <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_dest_q <= '0;
            out_tid_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            session_q  <= session_d;
            time_q     <= time_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            measure_q  <= measure_d;
            ptr_q      <= ptr_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_dest_q <= out_dest_d;
            out_tid_q  <= out_tid_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign session_id    = session_q;
    assign current_time  = time_q;
    assign measure       = measure_q;
    assign ts_out_TVALID = out_vld_q;
    assign ts_out_TDATA  = out_dat_q;
    assign ts_out_TDEST  = {{(16-IW){1'b0}}, out_dest_q};
    assign ts_out_TID    = out_tid_q;
    assign ts_out_TKEEP  = {8{out_vld_q}};
    assign ts_out_TLAST  = out_vld_q;

endmodule

// File: tb/tb_traffic_measure_ctrl.sv
// Directed bench for traffic_measure_ctrl: table-driven arbiter vectors plus
// hand-written session, abort, backpressure and asynchronous reset sequences.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_traffic_measure_ctrl;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         start;
    logic         abort;
    logic [31:0]  window_len;
    logic         busy;
    logic         done;
    logic [15:0]  session_id;
    logic [63:0]  current_time;
    logic         measure;
    logic [255:0] tdata;
    logic [3:0]   tv;
    logic [3:0]   in_rdy;
    logic [63:0]  out_dat;
    logic [7:0]   out_keep;
    logic [15:0]  out_dest;
    logic [15:0]  out_tid;
    logic         out_last;
    logic         out_vld;
    logic         tr;

    int n_chk  = 0;
    int n_pass = 0;

    traffic_measure_ctrl #(
        .N_LOGGERS    (4),
        .WINDOW_WIDTH (32),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .start         (start),
        .abort         (abort),
        .window_len    (window_len),
        .busy          (busy),
        .done          (done),
        .session_id    (session_id),
        .current_time  (current_time),
        .measure       (measure),
        .ts_in_TDATA   (tdata),
        .ts_in_TVALID  (tv),
        .ts_in_TREADY  (in_rdy),
        .ts_out_TDATA  (out_dat),
        .ts_out_TKEEP  (out_keep),
        .ts_out_TDEST  (out_dest),
        .ts_out_TID    (out_tid),
        .ts_out_TLAST  (out_last),
        .ts_out_TVALID (out_vld),
        .ts_out_TREADY (tr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tv;
        logic       rdy;
        logic [3:0] exp_irdy;
        logic       exp_vld;
        logic [1:0] exp_dest;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Steps until the session returns to IDLE after a done pulse, or the budget runs out.
    task automatic observe(input int budget, output int meas_n, output int last_meas,
                           output int done_at, output int done_n);
        meas_n = 0; last_meas = -1; done_at = -1; done_n = 0;
        for (int c = 0; c < budget; c++) begin
            if (measure) begin meas_n++; last_meas = c; end
            if (done) begin done_n++; if (done_at < 0) done_at = c; end
            if (done_n > 0 && !busy && !done) break;
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int mn, lm, da, dn, mc, pulses, dcount;
        logic held_ok, saw_done;
        logic [3:0] taken;

        for (int i = 0; i < 4; i++) tdata[64*i +: 64] = 64'hA0 + 64'(i);
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; window_len = '0; tv = '0; tr = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_measure", 64'(measure), 64'd0);
        chk("rst_session", 64'(session_id), 64'd0);
        chk("rst_time", current_time, 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_keep_last", 64'({out_keep, out_last}), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        chk("time_after_release", current_time, 64'd0);
        cyc();
        chk("time_first_incr", current_time, 64'd1);

        // ---------------- arbiter table (pointer starts at 0) ----------------
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[6]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        for (int r = 0; r < 13; r++) begin
            tv = tbl[r].tv;
            tr = tbl[r].rdy;
            #1;
            chk($sformatf("tbl%0d_in_rdy", r), 64'(in_rdy), 64'(tbl[r].exp_irdy));
            cyc();
            chk($sformatf("tbl%0d_out_vld", r), 64'(out_vld), 64'(tbl[r].exp_vld));
            if (tbl[r].exp_vld) begin
                chk($sformatf("tbl%0d_dest", r), 64'(out_dest), 64'(tbl[r].exp_dest));
                chk($sformatf("tbl%0d_data", r), out_dat, 64'hA0 + 64'(tbl[r].exp_dest));
                chk($sformatf("tbl%0d_tid", r), 64'(out_tid), 64'd0);
            end
        end
        tv = '0; tr = 1'b1;

        // ---------------- normal window, length 5 ----------------
        window_len = 32'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("win_busy_next", 64'(busy), 64'd1);
        chk("win_arm_measure_low", 64'(measure), 64'd0);
        chk("win_session", 64'(session_id), 64'd1);
        observe(60, mn, lm, da, dn);
        chk("win_measure_cycles", 64'(mn), 64'd5);
        chk("win_done_gap", 64'(da - lm), 64'd5);
        chk("win_done_pulses", 64'(dn), 64'd1);
        chk("win_idle_busy", 64'(busy), 64'd0);

        // ---------------- abort on 3rd MEASURE cycle ----------------
        window_len = 32'd100; start = 1'b1;
        cyc();
        start = 1'b0;
        mc = 0;
        repeat (3) begin
            cyc();
            if (measure) mc++;
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_measure_cycles", 64'(mc), 64'd3);
        chk("abort_measure_low", 64'(measure), 64'd0);
        window_len = 32'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("abort_start_in_drain_session", 64'(session_id), 64'd2);
        chk("abort_drain_busy", 64'(busy), 64'd1);
        observe(60, mn, lm, da, dn);
        chk("abort_no_remeasure", 64'(mn), 64'd0);
        chk("abort_done_pulses", 64'(dn), 64'd1);
        chk("abort_session_final", 64'(session_id), 64'd2);

        // ---------------- zero-length start ----------------
        window_len = 32'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero_busy", 64'(busy), 64'd0);
        dcount = 0;
        repeat (4) begin
            if (done || busy) dcount++;
            cyc();
        end
        chk("zero_no_activity", 64'(dcount), 64'd0);
        chk("zero_session", 64'(session_id), 64'd2);

        // ---------------- round-robin in a fresh session ----------------
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        window_len = 32'd20; start = 1'b1;
        cyc();
        start = 1'b0;
        tv = 4'b1111; tr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("rr%0d_vld", k), 64'(out_vld), 64'd1);
            chk($sformatf("rr%0d_dest", k), 64'(out_dest), 64'(k % 4));
            chk($sformatf("rr%0d_data", k), out_dat, 64'hA0 + 64'(k % 4));
            chk($sformatf("rr%0d_tid", k), 64'(out_tid), 64'd1);
        end
        chk("rr_keep", 64'(out_keep), 64'hFF);
        chk("rr_last", 64'(out_last), 64'd1);
        tv = '0;
        cyc();
        chk("rr_emptied", 64'(out_vld), 64'd0);
        observe(100, mn, lm, da, dn);
        chk("rr_done_pulses", 64'(dn), 64'd1);

        // ---------------- backpressure, loggers 1 and 2 ----------------
        window_len = 32'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        tv = 4'b0110; tr = 1'b0;
        pulses = 0; held_ok = 1'b1; saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            taken = in_rdy;
            if (in_rdy != '0) pulses++;
            cyc();
            tv = tv & ~taken;
            if (!(out_vld && out_dest == 16'd1 && out_dat == 64'hA1)) held_ok = 1'b0;
            if (done) saw_done = 1'b1;
        end
        chk("bp_in_rdy_pulses", 64'(pulses), 64'd1);
        chk("bp_beat_held", 64'(held_ok), 64'd1);
        chk("bp_drain_held_busy", 64'(busy), 64'd1);
        chk("bp_no_done", 64'(saw_done), 64'd0);
        tr = 1'b1;
        #1;
        taken = in_rdy;
        chk("bp_release_grant", 64'(in_rdy), 64'b0100);
        cyc();
        tv = tv & ~taken;
        chk("bp_second_vld", 64'(out_vld), 64'd1);
        chk("bp_second_dest", 64'(out_dest), 64'd2);
        chk("bp_second_data", out_dat, 64'hA2);
        cyc();
        chk("bp_emptied", 64'(out_vld), 64'd0);
        observe(40, mn, lm, da, dn);
        chk("bp_done_pulses", 64'(dn), 64'd1);

        // ---------------- asynchronous reset mid-MEASURE ----------------
        window_len = 32'd50; start = 1'b1;
        cyc();
        start = 1'b0;
        tv = 4'b0001; tr = 1'b0;
        cyc();
        tv = '0;
        cyc();
        chk("ar_pre_measure", 64'(measure), 64'd1);
        chk("ar_pre_vld", 64'(out_vld), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("ar_measure_drop", 64'(measure), 64'd0);
        chk("ar_vld_drop", 64'(out_vld), 64'd0);
        chk("ar_busy_drop", 64'(busy), 64'd0);
        chk("ar_session_zero", 64'(session_id), 64'd0);
        chk("ar_time_zero", current_time, 64'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        chk("ar_time_0", current_time, 64'd0);
        cyc();
        chk("ar_time_1", current_time, 64'd1);
        cyc();
        chk("ar_time_2", current_time, 64'd2);
        chk("ar_beat_discarded", 64'(out_vld), 64'd0);
        tr = 1'b1;
        window_len = 32'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ar_next_session", 64'(session_id), 64'd1);
        observe(40, mn, lm, da, dn);
        chk("ar_len1_measure", 64'(mn), 64'd1);
        chk("ar_len1_done", 64'(dn), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
